// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet II transmit framer and its CRC helper.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    PAY,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam int PREAMBLE_DIBITS = 31;
  localparam int MIN_PAYLOAD     = 46;
  localparam int MAX_PAYLOAD     = 1500;
  localparam int HDR_BYTES       = 14;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // One bit of the reflected CRC-32 recurrence.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic b);
    return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/eth_frame_tx_if.sv
// Byte-pull, control and RMII pin bundle between a frame source and eth_frame_tx.
interface eth_frame_tx_if;
  logic        start;
  logic [10:0] payload_len;
  logic        byte_req;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        axiov;
  logic [1:0]  axiod;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, payload_len, axiiv, axiid,
    input  byte_req, axiov, axiod, busy, done, err
  );

  modport slave (
    input  start, payload_len, axiiv, axiid,
    output byte_req, axiov, axiod, busy, done, err
  );
endinterface

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 consuming two bits per clock, LSB (d[0]) first; shared with the receive path.
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_step(crc32_step(crc_q, d[0]), d[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet II framer: preamble/SFD, fixed header, pulled payload, zero pad, FCS, gap, as RMII dibits.
// Define ETH_FRAME_TX_FCS_EN to build the CRC datapath and append the FCS.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC    = 48'h00_00_00_00_00_00,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          IFG_CYCLES = 48
) (
  input logic           clk,
  input logic           rst,
  eth_frame_tx_if.slave tx_if
);
  localparam logic [8*HDR_BYTES-1:0] HDR_VEC = {DST_MAC, SRC_MAC, ETHERTYPE};
`ifdef ETH_FRAME_TX_FCS_EN
  localparam tx_state_t AFTER_PAD = FCS;
`else
  localparam tx_state_t AFTER_PAD = IFG;
`endif

  tx_state_t   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [5:0]  ifg_q, ifg_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;

  logic [7:0]  hdr_bytes [HDR_BYTES];
  logic [7:0]  hdr_byte, tx_byte;
  logic [10:0] cnt_inc;
  logic [4:0]  pre_dibit;
  logic [1:0]  dibit;
  logic        tx_on, byte_end, need_next;

  for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
    assign hdr_bytes[gi] = HDR_VEC[8*(HDR_BYTES-1-gi) +: 8];
  end

  assign hdr_byte  = (cnt_q < 11'(HDR_BYTES)) ? hdr_bytes[cnt_q[3:0]] : 8'h00;
  assign cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign pre_dibit = {cnt_q[2:0], idx_q};
  assign tx_on     = state_q inside {PRE, HDR, PAY, PAD, FCS};
  assign byte_end  = tx_on && (idx_q == 2'd3);
  // A payload byte is owed for the next byte slot: after the last header byte or within PAY.
  assign need_next = ((state_q == HDR) && (cnt_q == 11'(HDR_BYTES-1)) && (len_q != 11'd0)) ||
                     ((state_q == PAY) && (cnt_inc < len_q));

`ifdef ETH_FRAME_TX_FCS_EN
  logic [31:0] crc, fcs;

  crc32_dibit u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == PRE && pre_dibit == 5'(PREAMBLE_DIBITS)),
    .en    (state_q inside {HDR, PAY, PAD}),
    .d     (dibit),
    .crc   (crc)
  );

  assign fcs = ~crc;
`endif

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      HDR: tx_byte = hdr_byte;
      PAY: tx_byte = data_q;
`ifdef ETH_FRAME_TX_FCS_EN
      FCS: tx_byte = fcs[{cnt_q[1:0], 3'b000} +: 8];
`endif
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    dibit = 2'b00;
    if (state_q == PRE) begin
      dibit = (pre_dibit == 5'(PREAMBLE_DIBITS)) ? 2'b11 : 2'b01;
    end else if (tx_on) begin
      dibit = tx_byte[{idx_q, 1'b0} +: 2];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ifg_d   = ifg_q;
    len_d   = len_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (tx_on) idx_d = idx_q + 2'd1;
    case (state_q)
      IDLE: begin
        if (tx_if.start) begin
          if (tx_if.payload_len <= 11'(MAX_PAYLOAD)) begin
            state_d = PRE;
            len_d   = tx_if.payload_len;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      IFG: begin
        ifg_d = ifg_q + 6'd1;
        if (ifg_q == 6'(IFG_CYCLES-1)) state_d = IDLE;
      end
      default: begin
        if (byte_end) begin
          cnt_d = cnt_inc;
          if (need_next && !tx_if.axiiv) begin
            state_d = IFG;
            ifg_d   = '0;
            err_d   = 1'b1;
          end else begin
            if (need_next) data_d = tx_if.axiid;
            case (state_q)
              PRE: if (cnt_q == 11'd7) begin
                state_d = HDR;
                cnt_d   = '0;
              end
              HDR: if (cnt_q == 11'(HDR_BYTES-1)) begin
                state_d = need_next ? PAY : PAD;
                cnt_d   = '0;
              end
              PAY: if (!need_next) begin
                if (len_q < 11'(MIN_PAYLOAD)) begin
                  state_d = PAD;
                end else begin
                  state_d = AFTER_PAD;
                  cnt_d   = '0;
                  ifg_d   = '0;
                end
              end
              PAD: if (cnt_q == 11'(MIN_PAYLOAD-1)) begin
                state_d = AFTER_PAD;
                cnt_d   = '0;
                ifg_d   = '0;
              end
              FCS: if (cnt_q == 11'd3) begin
                state_d = IFG;
                ifg_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ifg_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      len_q   <= len_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign tx_if.axiov    = tx_on;
  assign tx_if.axiod    = dibit;
  assign tx_if.byte_req = need_next && (idx_q == 2'd2);
  assign tx_if.busy     = (state_q != IDLE);
  assign tx_if.done     = (state_q == IFG) && (ifg_q == 6'(IFG_CYCLES-1));
  assign tx_if.err      = err_q;
endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: byte-level frame model plus per-cycle comparison of every output.
module tb_eth_frame_tx;
  typedef logic [7:0] bq_t[$];

`ifdef ETH_FRAME_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif
  localparam int IFG = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  eth_frame_tx_if bus ();
  eth_frame_tx dut (.clk(clk), .rst(rst), .tx_if(bus));

  logic        c_clear = 1'b0;
  logic        c_en    = 1'b0;
  logic [1:0]  c_d     = 2'b00;
  logic [31:0] c_crc;
  crc32_dibit u_crc (.clk(clk), .rst(rst), .clear(c_clear), .en(c_en), .d(c_d), .crc(c_crc));

  int  n_cmp = 0;
  int  n_bad = 0;
  bq_t pay_q;
  int  req_idx  = 0;
  int  withhold = -1;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // {byte_req, axiov, axiod[1:0], busy, done, err}
  function automatic logic [6:0] obs();
    return {bus.byte_req, bus.axiov, bus.axiod, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [31:0] sw_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t build_frame(input bq_t pay);
    bq_t fr, body;
    logic [111:0] hv;
    logic [31:0] f;
    hv = {48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 16'h88B5};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int k = 0; k < 14; k++) body.push_back(hv[111-8*k -: 8]);
    foreach (pay[i]) body.push_back(pay[i]);
    while (body.size() < 14 + 46) body.push_back(8'h00);
    f = sw_crc(body);
    foreach (body[i]) fr.push_back(body[i]);
    for (int k = 0; k < FCS_BYTES; k++) fr.push_back(f[8*k +: 8]);
    return fr;
  endfunction

  // Answers each byte_req one cycle later; otherwise emits random stray axiiv pulses.
  initial begin : responder
    logic req_seen;
    bus.axiiv = 1'b0;
    bus.axiid = 8'h00;
    forever begin
      @(negedge clk);
      req_seen = bus.byte_req;
      @(posedge clk);
      #1;
      if (req_seen) begin
        if (req_idx != withhold && pay_q.size() > 0) begin
          bus.axiiv = 1'b1;
          bus.axiid = pay_q.pop_front();
        end else begin
          bus.axiiv = 1'b0;
          bus.axiid = 8'h00;
        end
        req_idx++;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.axiiv = 1'b1;
        bus.axiid = 8'($urandom);
      end else begin
        bus.axiiv = 1'b0;
      end
    end
  end

  task automatic run_frame(input int len, input int wh, input bit inject, input int tail);
    bq_t pay, fr;
    logic [1:0] dq[$];
    logic [7:0] b;
    logic [6:0] e;
    int n_exp, n_req, last, ov_cnt;
    ov_cnt = 0;
    for (int i = 0; i < len; i++) pay.push_back((len == 3) ? 8'(i + 1) : 8'($urandom_range(0, 255)));
    fr = build_frame(pay);
    foreach (fr[i]) begin
      b = fr[i];
      for (int j = 0; j < 4; j++) dq.push_back(b[2*j +: 2]);
    end
    n_exp = (wh < 0) ? dq.size() : 4 * (22 + wh);
    n_req = (wh < 0) ? len : wh + 1;
    last  = n_exp + IFG - 1 + tail;
    pay_q = pay;
    req_idx = 0;
    withhold = wh;
    @(negedge clk);
    bus.start = 1'b1;
    bus.payload_len = 11'(len);
    @(negedge clk);
    bus.start = 1'b0;
    bus.payload_len = 11'($urandom_range(0, 2047));
    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);
      e = '0;
      if (c < n_exp) begin
        e[5]   = 1'b1;
        e[4:3] = dq[c];
      end
      e[6] = (c >= 86) && ((c - 86) % 4 == 0) && ((c - 86) / 4 < n_req);
      e[2] = (c < n_exp + IFG);
      e[1] = (c == n_exp + IFG - 1);
      e[0] = (wh >= 0) && (c == n_exp);
      check("frame", c, 32'(obs()), 32'(e));
      if (bus.axiov) ov_cnt++;
      if (inject) bus.start = (c == 50);
    end
    bus.start = 1'b0;
    $display("frame len=%0d underrun_at=%0d wire_cycles=%0d model_cycles=%0d", len, wh, ov_cnt, n_exp);
  endtask

  task automatic run_reject(input int len);
    @(negedge clk);
    bus.start = 1'b1;
    bus.payload_len = 11'(len);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      check("reject", c, 32'(obs()), (c == 0) ? 32'h1 : 32'h0);
    end
    $display("reject len=%0d", len);
  endtask

  initial begin : main
    bq_t s9, fr, pay;
    string s;
    logic [7:0] b;
    bus.start = 1'b0;
    bus.payload_len = 11'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 0, 32'(obs()), 32'h0);
    rst = 1'b0;

    s = "123456789";
    for (int i = 0; i < s.len(); i++) s9.push_back(s[i]);
    check("model_crc_check", 0, sw_crc(s9), 32'hCBF43926);
    pay = '{8'h01, 8'h02, 8'h03};
    fr = build_frame(pay);
    check("model_len3_cycles", 0, 32'(4 * fr.size()), (FCS_BYTES == 4) ? 32'd288 : 32'd272);
    check("model_sfd", 0, 32'(fr[7]), 32'hD5);
    check("model_ethertype_lo", 0, 32'(fr[21]), 32'hB5);
    check("model_first_pad", 0, 32'(fr[25]), 32'h00);
    pay = {};
    for (int i = 0; i < 100; i++) pay.push_back(8'(i));
    fr = build_frame(pay);
    check("model_len100_cycles", 0, 32'(4 * fr.size()), (FCS_BYTES == 4) ? 32'd504 : 32'd488);

    @(negedge clk);
    c_clear = 1'b1;
    @(negedge clk);
    c_clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = s9[i];
        c_d = b[2*j +: 2];
        c_en = 1'b1;
        @(negedge clk);
      end
    end
    c_en = 1'b0;
    check("crc32_dibit_check", 0, ~c_crc, 32'hCBF43926);
    $display("crc32_dibit check value %h", ~c_crc);

    run_frame(3, -1, 1'b0, 2);
    run_frame(100, -1, 1'b1, 2);
    run_frame(0, -1, 1'b0, 2);
    run_frame(46, -1, 1'b0, 0);
    run_frame(47, -1, 1'b0, 2);
    run_reject(1501);
    run_reject(2047);
    run_frame(60, 9, 1'b0, 2);
    run_frame(20, 0, 1'b0, 2);
    repeat (4) run_frame($urandom_range(1, 200), -1, 1'b0, $urandom_range(0, 2));
    run_frame(1500, -1, 1'b0, 2);

    pay = {};
    for (int i = 0; i < 200; i++) pay.push_back(8'($urandom_range(0, 255)));
    pay_q = pay;
    req_idx = 0;
    withhold = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.payload_len = 11'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pay", 0, 32'(obs()), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", 1, 32'(obs()), 32'h0);
    $display("reset during payload of len=200");
    run_frame(0, -1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
